mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage directly downstream of the execute stage, fed through the ex_mem pipeline latch.
- Executes LB/LH/LW/LBU/LHU/SB/SH/SW as multi-cycle byte-serial transactions on the 8-bit memory-controller port.
- Holds the pipeline via a stall request while a transaction is in flight.
- Passes all non-memory results straight through to mem_wb.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, register data width.
- REG_AW, 5, register address width.

Ports:
- clk_in  in  1  clock, rising edge
- rst_n_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global ready; 0 freezes the block
- rd_address_in  in  REG_AW  destination register from ex_mem
- rd_data_in  in  DATA_W  ALU result, or store data for stores
- inst_in  in  `InstShort  instruction short code from ex_mem
- mem_address_in  in  ADDR_W  effective address computed by execute
- rd_address_out  out  REG_AW  destination register to mem_wb and id forwarding
- rd_data_out  out  DATA_W  result to mem_wb and id forwarding
- wb_enable_out  out  1  rd_address_out/rd_data_out valid this cycle
- stall_req_out  out  1  hold if/id/ex and the ex_mem latch
- mem_req_out  out  1  byte access requested
- mem_wr_out  out  1  1 = write byte, 0 = read byte
- mem_addr_out  out  ADDR_W  byte address
- mem_wdata_out  out  8  write byte
- mem_gnt_in  in  1  current byte request accepted this cycle
- mem_rdata_in  in  8  read byte, valid the cycle after its grant

Behaviour:
- Reset (rst_n_in=0, asynchronous):
  - State returns to IDLE; byte index and pending-read flag clear.
  - All outputs are 0.
  - Any in-flight transaction is abandoned; a read byte arriving after reset is ignored.
- rdy_in=0:
  - All registers hold.
  - mem_req_out=0, wb_enable_out=0.
  - stall_req_out keeps its current value.
  - mem_gnt_in is ignored.
- States: IDLE, ACCESS, DRAIN, DONE.
- IDLE, non-memory inst_in (combinational pass-through):
  - rd_address_out=rd_address_in, rd_data_out=rd_data_in.
  - wb_enable_out=1 when rd_address_in is not 0, else 0.
  - stall_req_out=0.
  - instNOP produces all zeros.
- IDLE, load/store inst_in:
  - stall_req_out=1 combinationally in the same cycle; wb_enable_out=0.
  - At the next edge, latch op, base address, store data and rd.
  - Set byte count N: 1 for B/BU, 2 for H/HU, 4 for W. Set idx=0. Go to ACCESS.
- ACCESS:
  - Outputs: mem_req_out=1, mem_addr_out=base+idx (modulo 2^ADDR_W, so wrap-around is allowed), mem_wr_out=is_store, mem_wdata_out=store_data[8*idx+7:8*idx].
  - On mem_gnt_in: idx increments. For loads, the pending-read flag is set with slot=idx.
  - Without a grant: address and data are held unchanged; any number of gap cycles is allowed.
  - Whenever the pending-read flag is set, mem_rdata_in is written into buffer byte[slot].
  - Grant on the last byte (idx=N-1): stores go to DONE, loads go to DRAIN.
- DRAIN:
  - mem_req_out=0.
  - Capture the final read byte, then go to DONE.
- DONE (one cycle):
  - stall_req_out=0, wb_enable_out=1 for loads with rd not 0.
  - rd_address_out is the latched rd; rd_data_out is the extended load value.
  - Stores: wb_enable_out=0 and rd_data_out=0.
  - inst_in is ignored during this cycle, because the upstream latch still presents the old instruction. Go to IDLE.
- stall_req_out is 1 from the capture cycle through DRAIN inclusive.
- Load extension (little-endian):
  - LB: sign-extend byte0. LBU: zero-extend byte0.
  - LH: sign-extend {byte1,byte0}. LHU: zero-extend {byte1,byte0}.
  - LW: {byte3,byte2,byte1,byte0}.
- Latency with continuous grants, capture cycle = C:
  - LW: DONE at C+6. LB: DONE at C+3.
  - SW: DONE at C+5. SB: DONE at C+2.
- No alignment check; misaligned halfword/word accesses complete byte-wise.

Decomposition:
- Shared defines: InstShort codes (already present), plus new `MemStIdle, `MemStAccess, `MemStDrain, `MemStDone state encodings and a `MemByteBus width.
- One combinational sub-module, mem_load_ext: inputs are op and the 32-bit raw buffer; output is the extended rd value.

Test Plan:
- LW addr 0x100, grants every cycle, memory returns 0x78,0x56,0x34,0x12:
  - mem_addr_out is 0x100..0x103 on C+1..C+4.
  - At C+6: rd_data_out=0x12345678, wb_enable_out=1, stall_req_out=0.
- LB and LBU at an address holding 0x80:
  - LB gives rd_data_out=0xFFFFFF80; LBU gives 0x00000080.
  - LH at {0x01,0x80}, i.e. 0x8001, gives 0xFFFF8001.
- SH addr 0x200, rd_data_in=0xDEADBEEF:
  - Writes 0xEF@0x200 then 0xBE@0x201, mem_wr_out=1.
  - DONE at C+3 with wb_enable_out=0.
- SW addr 0xFFFFFFFE, mem_gnt_in low for 2 cycles before each grant:
  - Addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1; each is held steady during the gaps.
  - stall_req_out stays high until DONE.
- LW with rdy_in=0 for 3 cycles mid-ACCESS:
  - No req, state frozen; the result is identical once rdy_in returns.
- Reset asserted mid-LW:
  - All outputs 0 immediately, state IDLE.
  - A late mem_rdata_in is ignored.
  - The following ADDI passes rd_data_in=0x5 through with wb_enable_out=1 in the same cycle.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared types for the memory stage: instruction short codes, FSM states,
// memory byte-bus width and small decode helpers.
package mem_access_pkg;

   localparam int INST_W     = 6;
   localparam int MEM_BYTE_W = 8;

   typedef enum logic [INST_W-1:0] {
      INST_NOP  = 6'd0,
      INST_ADD  = 6'd1,
      INST_ADDI = 6'd2,
      INST_LB   = 6'd3,
      INST_LH   = 6'd4,
      INST_LW   = 6'd5,
      INST_LBU  = 6'd6,
      INST_LHU  = 6'd7,
      INST_SB   = 6'd8,
      INST_SH   = 6'd9,
      INST_SW   = 6'd10
   } inst_e;

   typedef enum logic [1:0] {
      MEM_ST_IDLE   = 2'd0,
      MEM_ST_ACCESS = 2'd1,
      MEM_ST_DRAIN  = 2'd2,
      MEM_ST_DONE   = 2'd3
   } mem_st_e;

   function automatic logic is_load(input logic [INST_W-1:0] op);
      return (op == INST_LB) || (op == INST_LH) || (op == INST_LW) ||
             (op == INST_LBU) || (op == INST_LHU);
   endfunction

   function automatic logic is_store(input logic [INST_W-1:0] op);
      return (op == INST_SB) || (op == INST_SH) || (op == INST_SW);
   endfunction

   // Index of the last byte of the access (byte count minus one).
   function automatic logic [1:0] last_byte_idx(input logic [INST_W-1:0] op);
      logic [1:0] r;
      r = 2'd0;
      if ((op == INST_LH) || (op == INST_LHU) || (op == INST_SH)) r = 2'd1;
      if ((op == INST_LW) || (op == INST_SW))                     r = 2'd3;
      return r;
   endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Little-endian load extension of the assembled byte buffer.
module mem_load_ext
   import mem_access_pkg::*;
#(
   parameter int DATA_W = 32
)(
   input  logic [INST_W-1:0] op,
   input  logic [31:0]       raw,
   output logic [DATA_W-1:0] ext
);

   // Sign/zero extend according to the load flavour; non-loads give 0.
   always_comb begin
      ext = '0;
      case (op)
         INST_LB:  ext = {{(DATA_W-8){raw[7]}},   raw[7:0]};
         INST_LBU: ext = {{(DATA_W-8){1'b0}},     raw[7:0]};
         INST_LH:  ext = {{(DATA_W-16){raw[15]}}, raw[15:0]};
         INST_LHU: ext = {{(DATA_W-16){1'b0}},    raw[15:0]};
         INST_LW:  ext = DATA_W'(raw);
         default:  ext = '0;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory stage: byte-serial loads/stores on an 8-bit controller port,
// pass-through of non-memory results, pipeline stall while busy.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
)(
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  rdy_in,
   input  logic [REG_AW-1:0]     rd_address_in,
   input  logic [DATA_W-1:0]     rd_data_in,
   input  logic [INST_W-1:0]     inst_in,
   input  logic [ADDR_W-1:0]     mem_address_in,
   output logic [REG_AW-1:0]     rd_address_out,
   output logic [DATA_W-1:0]     rd_data_out,
   output logic                  wb_enable_out,
   output logic                  stall_req_out,
   output logic                  mem_req_out,
   output logic                  mem_wr_out,
   output logic [ADDR_W-1:0]     mem_addr_out,
   output logic [MEM_BYTE_W-1:0] mem_wdata_out,
   input  logic                  mem_gnt_in,
   input  logic [MEM_BYTE_W-1:0] mem_rdata_in
);

   mem_st_e              state_q, state_d;
   logic [INST_W-1:0]    op_q;
   logic [ADDR_W-1:0]    base_q;
   logic [DATA_W-1:0]    sdata_q;
   logic [REG_AW-1:0]    rd_q;
   logic [1:0]           idx_q, last_q, slot_q;
   logic                 pend_q;
   logic [31:0]          buf_q;
   logic [DATA_W-1:0]    ld_val;
   logic                 in_mem, grant, q_store, q_load, capture;

   assign in_mem  = is_load(inst_in) || is_store(inst_in);
   assign q_store = is_store(op_q);
   assign q_load  = is_load(op_q);
   assign capture = (state_q == MEM_ST_IDLE) && in_mem;
   // A grant only counts while the block is running and actually requesting.
   assign grant   = rdy_in && (state_q == MEM_ST_ACCESS) && mem_gnt_in;

   mem_load_ext #(.DATA_W(DATA_W)) u_ext (
      .op  (op_q),
      .raw (buf_q),
      .ext (ld_val)
   );

   // FSM state register; rdy_in low freezes it.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)   state_q <= MEM_ST_IDLE;
      else if (rdy_in) state_q <= state_d;
   end

   // Transaction datapath: latch on capture, walk bytes on grants, collect read bytes.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         op_q    <= '0;
         base_q  <= '0;
         sdata_q <= '0;
         rd_q    <= '0;
         idx_q   <= '0;
         last_q  <= '0;
         slot_q  <= '0;
         pend_q  <= 1'b0;
         buf_q   <= '0;
      end else if (rdy_in) begin
         if (capture) begin
            op_q    <= inst_in;
            base_q  <= mem_address_in;
            sdata_q <= rd_data_in;
            rd_q    <= rd_address_in;
            last_q  <= last_byte_idx(inst_in);
            idx_q   <= '0;
         end
         if (grant) begin
            idx_q  <= idx_q + 2'd1;
            slot_q <= idx_q;
         end
         // Read data trails its grant by one cycle, so remember where it goes.
         pend_q <= grant && q_load;
         if (pend_q) buf_q[{slot_q, 3'b000} +: MEM_BYTE_W] <= mem_rdata_in;
      end
   end

   // Next-state and output decode; everything reads 0 while reset is held.
   always_comb begin
      state_d        = state_q;
      rd_address_out = '0;
      rd_data_out    = '0;
      wb_enable_out  = 1'b0;
      stall_req_out  = 1'b0;
      mem_req_out    = 1'b0;
      mem_wr_out     = 1'b0;
      mem_addr_out   = '0;
      mem_wdata_out  = '0;
      case (state_q)
         MEM_ST_IDLE: begin
            if (in_mem) begin
               state_d       = MEM_ST_ACCESS;
               stall_req_out = 1'b1;
            end else if (inst_in != INST_NOP) begin
               rd_address_out = rd_address_in;
               rd_data_out    = rd_data_in;
               wb_enable_out  = rdy_in && (rd_address_in != '0);
            end
         end
         MEM_ST_ACCESS: begin
            if (grant && (idx_q == last_q)) state_d = q_store ? MEM_ST_DONE : MEM_ST_DRAIN;
            stall_req_out = 1'b1;
            mem_req_out   = rdy_in;
            mem_wr_out    = q_store;
            mem_addr_out  = base_q + ADDR_W'(idx_q);
            mem_wdata_out = sdata_q[{idx_q, 3'b000} +: MEM_BYTE_W];
         end
         MEM_ST_DRAIN: begin
            state_d       = MEM_ST_DONE;
            stall_req_out = 1'b1;
         end
         MEM_ST_DONE: begin
            // inst_in still shows the finished instruction here; ignore it.
            state_d        = MEM_ST_IDLE;
            rd_address_out = rd_q;
            rd_data_out    = q_store ? '0 : ld_val;
            wb_enable_out  = rdy_in && q_load && (rd_q != '0);
         end
         default: state_d = MEM_ST_IDLE;
      endcase
      if (!rst_n_in) begin
         rd_address_out = '0;
         rd_data_out    = '0;
         wb_enable_out  = 1'b0;
         stall_req_out  = 1'b0;
         mem_req_out    = 1'b0;
         mem_wr_out     = 1'b0;
         mem_addr_out   = '0;
         mem_wdata_out  = '0;
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a simple byte-memory responder.
module tb_mem_access;
   import mem_access_pkg::*;

   logic              clk_in = 1'b0;
   logic              rst_n_in;
   logic              rdy_in;
   logic [4:0]        rd_address_in;
   logic [31:0]       rd_data_in;
   logic [INST_W-1:0] inst_in;
   logic [31:0]       mem_address_in;
   logic [4:0]        rd_address_out;
   logic [31:0]       rd_data_out;
   logic              wb_enable_out, stall_req_out, mem_req_out, mem_wr_out;
   logic [31:0]       mem_addr_out;
   logic [7:0]        mem_wdata_out;
   logic              mem_gnt_in;
   logic [7:0]        mem_rdata_in = 8'h00;

   logic [7:0]        rmem [bit [31:0]];
   int                checks = 0;
   int                errors = 0;

   mem_access dut (
      .clk_in         (clk_in),
      .rst_n_in       (rst_n_in),
      .rdy_in         (rdy_in),
      .rd_address_in  (rd_address_in),
      .rd_data_in     (rd_data_in),
      .inst_in        (inst_in),
      .mem_address_in (mem_address_in),
      .rd_address_out (rd_address_out),
      .rd_data_out    (rd_data_out),
      .wb_enable_out  (wb_enable_out),
      .stall_req_out  (stall_req_out),
      .mem_req_out    (mem_req_out),
      .mem_wr_out     (mem_wr_out),
      .mem_addr_out   (mem_addr_out),
      .mem_wdata_out  (mem_wdata_out),
      .mem_gnt_in     (mem_gnt_in),
      .mem_rdata_in   (mem_rdata_in)
   );

   always #5 clk_in = ~clk_in;

   // Memory responder: read byte appears the cycle after its grant and then holds.
   always @(posedge clk_in)
      if (rst_n_in && rdy_in && mem_req_out && mem_gnt_in && !mem_wr_out)
         mem_rdata_in <= rmem.exists(mem_addr_out) ? rmem[mem_addr_out] : 8'h00;

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      inst_in = INST_NOP; rd_address_in = '0; rd_data_in = '0; mem_address_in = '0;
   endtask

   // Full access with grants every cycle; checks addresses, write bytes and the DONE cycle.
   task automatic do_access(input string tag, input inst_e op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [4:0] rd, input int n,
                            input logic st, input logic [31:0] exp);
      step();
      inst_in = op; mem_address_in = addr; rd_data_in = data; rd_address_in = rd;
      settle();
      chk({tag, " cap stall"}, 32'(stall_req_out), 32'd1);
      chk({tag, " cap wb"}, 32'(wb_enable_out), 32'd0);
      for (int i = 0; i < n; i++) begin
         step(); settle();
         chk({tag, " req"}, 32'(mem_req_out), 32'd1);
         chk({tag, " addr"}, mem_addr_out, addr + 32'(i));
         chk({tag, " wr"}, 32'(mem_wr_out), 32'(st));
         if (st) chk({tag, " wdata"}, 32'(mem_wdata_out), 32'(data[8*i +: 8]));
      end
      if (!st) begin
         step(); settle();
         chk({tag, " drain req"}, 32'(mem_req_out), 32'd0);
         chk({tag, " drain stall"}, 32'(stall_req_out), 32'd1);
      end
      step(); settle();
      chk({tag, " done stall"}, 32'(stall_req_out), 32'd0);
      chk({tag, " done wb"}, 32'(wb_enable_out), 32'(!st && (rd != 5'd0)));
      chk({tag, " done data"}, rd_data_out, st ? 32'd0 : exp);
      chk({tag, " done rd"}, 32'(rd_address_out), 32'(rd));
      step(); idle_inputs(); settle();
      chk({tag, " after stall"}, 32'(stall_req_out), 32'd0);
   endtask

   initial begin
      rmem[32'h100] = 8'h78; rmem[32'h101] = 8'h56; rmem[32'h102] = 8'h34; rmem[32'h103] = 8'h12;
      rmem[32'h300] = 8'h80;
      rmem[32'h310] = 8'h01; rmem[32'h311] = 8'h80;
      rmem[32'h400] = 8'h44; rmem[32'h401] = 8'h33; rmem[32'h402] = 8'h22; rmem[32'h403] = 8'h11;
      rmem[32'h500] = 8'h01; rmem[32'h501] = 8'h02; rmem[32'h502] = 8'h03; rmem[32'h503] = 8'h04;

      // Reset: outputs zero even with a live ADDI presented.
      rst_n_in = 1'b0; rdy_in = 1'b1; mem_gnt_in = 1'b1;
      inst_in = INST_ADDI; rd_address_in = 5'd5; rd_data_in = 32'h7; mem_address_in = '0;
      #3;
      chk("rst rd_data", rd_data_out, 32'd0);
      chk("rst wb", 32'(wb_enable_out), 32'd0);
      chk("rst rd", 32'(rd_address_out), 32'd0);
      chk("rst stall", 32'(stall_req_out), 32'd0);
      chk("rst req", 32'(mem_req_out), 32'd0);
      step(); step();
      rst_n_in = 1'b1; settle();

      // Non-memory pass-through.
      chk("addi data", rd_data_out, 32'h7);
      chk("addi wb", 32'(wb_enable_out), 32'd1);
      chk("addi rd", 32'(rd_address_out), 32'd5);
      rd_address_in = 5'd0; #1;
      chk("addi rd0 wb", 32'(wb_enable_out), 32'd0);
      inst_in = INST_NOP; rd_address_in = 5'd9; rd_data_in = 32'h33; #1;
      chk("nop data", rd_data_out, 32'd0);
      chk("nop wb", 32'(wb_enable_out), 32'd0);
      inst_in = INST_ADD; rdy_in = 1'b0; #1;
      chk("rdy0 wb", 32'(wb_enable_out), 32'd0);
      rdy_in = 1'b1; idle_inputs();

      // Continuous-grant loads and stores.
      do_access("lw",  INST_LW,  32'h100, 32'h0, 5'd5, 4, 1'b0, 32'h12345678);
      do_access("lb",  INST_LB,  32'h300, 32'h0, 5'd6, 1, 1'b0, 32'hFFFFFF80);
      do_access("lbu", INST_LBU, 32'h300, 32'h0, 5'd6, 1, 1'b0, 32'h00000080);
      do_access("lh",  INST_LH,  32'h310, 32'h0, 5'd7, 2, 1'b0, 32'hFFFF8001);
      do_access("lhu", INST_LHU, 32'h310, 32'h0, 5'd7, 2, 1'b0, 32'h00008001);
      do_access("lwr0", INST_LW, 32'h100, 32'h0, 5'd0, 4, 1'b0, 32'h12345678);
      do_access("sh",  INST_SH,  32'h200, 32'hDEADBEEF, 5'd0, 2, 1'b1, 32'h0);
      do_access("sb",  INST_SB,  32'h210, 32'h12345699, 5'd4, 1, 1'b1, 32'h0);

      // SW across the address wrap with two idle cycles before each grant.
      step();
      inst_in = INST_SW; mem_address_in = 32'hFFFFFFFE; rd_data_in = 32'hA1B2C3D4;
      rd_address_in = 5'd0; mem_gnt_in = 1'b0;
      settle();
      chk("sw cap stall", 32'(stall_req_out), 32'd1);
      for (int b = 0; b < 4; b++) begin
         for (int g = 0; g < 3; g++) begin
            step(); mem_gnt_in = (g == 2); settle();
            chk("sw addr", mem_addr_out, 32'hFFFFFFFE + 32'(b));
            chk("sw wdata", 32'(mem_wdata_out), 32'((32'hA1B2C3D4 >> (8*b)) & 32'hFF));
            chk("sw req", 32'(mem_req_out), 32'd1);
            chk("sw stall", 32'(stall_req_out), 32'd1);
         end
      end
      step(); mem_gnt_in = 1'b1; settle();
      chk("sw done stall", 32'(stall_req_out), 32'd0);
      chk("sw done wb", 32'(wb_enable_out), 32'd0);
      chk("sw done req", 32'(mem_req_out), 32'd0);
      step(); idle_inputs();

      // LW frozen by rdy_in low for three cycles mid-access.
      step();
      inst_in = INST_LW; mem_address_in = 32'h400; rd_address_in = 5'd8; settle();
      step(); settle(); chk("rdy addr0", mem_addr_out, 32'h400);
      step(); settle(); chk("rdy addr1", mem_addr_out, 32'h401);
      for (int i = 0; i < 3; i++) begin
         step(); rdy_in = 1'b0; settle();
         chk("rdy0 req", 32'(mem_req_out), 32'd0);
         chk("rdy0 wb2", 32'(wb_enable_out), 32'd0);
         chk("rdy0 stall", 32'(stall_req_out), 32'd1);
      end
      step(); rdy_in = 1'b1; settle();
      chk("rdy addr2", mem_addr_out, 32'h402);
      chk("rdy req2", 32'(mem_req_out), 32'd1);
      step(); settle(); chk("rdy addr3", mem_addr_out, 32'h403);
      step(); settle(); chk("rdy drain", 32'(stall_req_out), 32'd1);
      step(); settle();
      chk("rdy data", rd_data_out, 32'h11223344);
      chk("rdy wb", 32'(wb_enable_out), 32'd1);
      chk("rdy stall", 32'(stall_req_out), 32'd0);
      chk("rdy rd", 32'(rd_address_out), 32'd8);
      step(); idle_inputs();

      // Reset in the middle of a LW, then an ADDI straight after.
      step();
      inst_in = INST_LW; mem_address_in = 32'h500; rd_address_in = 5'd7; settle();
      step(); settle(); chk("mrst addr0", mem_addr_out, 32'h500);
      step(); settle(); chk("mrst addr1", mem_addr_out, 32'h501);
      step(); rst_n_in = 1'b0; settle();
      chk("mrst req", 32'(mem_req_out), 32'd0);
      chk("mrst stall", 32'(stall_req_out), 32'd0);
      chk("mrst addr", mem_addr_out, 32'd0);
      chk("mrst data", rd_data_out, 32'd0);
      chk("mrst wb", 32'(wb_enable_out), 32'd0);
      step();
      inst_in = INST_ADDI; rd_address_in = 5'd3; rd_data_in = 32'h5; mem_address_in = '0;
      step(); rst_n_in = 1'b1; settle();
      chk("post addi data", rd_data_out, 32'h5);
      chk("post addi wb", 32'(wb_enable_out), 32'd1);
      chk("post addi rd", 32'(rd_address_out), 32'd3);
      chk("post addi stall", 32'(stall_req_out), 32'd0);
      chk("post addi req", 32'(mem_req_out), 32'd0);
      step(); idle_inputs(); settle();
      chk("post idle req", 32'(mem_req_out), 32'd0);
      chk("post idle stall", 32'(stall_req_out), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
